// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serialising memory arbiter.
package mem_arb_pkg;

    // Transaction FSM: one IDLE cycle separates every pair of transactions.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    // Size field encodings (size = bytes-1).
    localparam int SZ_B = 0;
    localparam int SZ_H = 1;
    localparam int SZ_W = 3;

    // Byte counter width: a read runs up to 9 cycles for a 64-bit port.
    localparam int CNT_W = 4;

    // Selects byte lane 'lane' of a little-endian word (lane 0 = bits [7:0]).
    function automatic logic [7:0] byte_lane(input logic [63:0] word, input logic [2:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Grant selection over eligible requesters (req & ~abort).
// MEM_ARB_RR_EN defined: round-robin with a start pointer that moves past each grant.
// MEM_ARB_RR_EN undefined: fixed priority, highest port index wins; no state is built.
module mem_arb_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
`ifdef MEM_ARB_RR_EN
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 grant_take,
`endif
    input  logic [NUM_PORTS-1:0] req_mask,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx
);

`ifdef MEM_ARB_RR_EN
    // ptr_reg holds the port where the next search begins (last grant + 1).
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;

    // Scan from ptr_reg upward with wrap; iterate backwards so the nearest port wins.
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(ptr_reg) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (req_mask[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
        ptr_next = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end

    // Advance the search start past the port just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant_take) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    // Last match wins, so the highest eligible index is granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_mask[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter onto a byte-wide RAM with 1-cycle read latency.
// Multi-byte little-endian reads/writes are serialised into byte accesses.
// Build option: MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SIZE_W    = $clog2(DATA_W / 8)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS-1:0]          abort,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*SIZE_W-1:0]   size,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          done,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_wr,
    output logic [7:0]                    ram_dout,
    input  logic [7:0]                    ram_din
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   port_reg;
    logic [ADDR_W-1:0]  ram_addr_reg;
    logic [SIZE_W-1:0]  size_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         rbuf_reg [NB];

    logic [ADDR_W-1:0]  addr_arr  [NUM_PORTS];
    logic [SIZE_W-1:0]  size_arr  [NUM_PORTS];
    logic [DATA_W-1:0]  wdata_arr [NUM_PORTS];

    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_fire;
    logic [CNT_W-1:0]   size_ext;
    logic               rd_done;
    logic               wr_done;
    logic               rd_abort;

    // Unpack the flat per-port buses.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign size_arr[gi]  = size[gi*SIZE_W +: SIZE_W];
        assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .grant_take  (grant_fire),
`endif
        .req_mask    (req & ~abort),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // cnt_reg = cycle index - 1 within a transaction. Reads finish one cycle
    // after the last address (RAM latency); writes finish with the last byte.
    assign grant_fire = (state_reg == IDLE) && grant_valid;
    assign size_ext   = CNT_W'(size_reg);
    assign rd_done    = (state_reg == RD) && (cnt_reg == size_ext + CNT_W'(1));
    assign wr_done    = (state_reg == WR) && (cnt_reg == size_ext);
    assign rd_abort   = (state_reg == RD) && abort[port_reg] && !rd_done;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: aborts only cancel reads, and done beats a same-cycle abort.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_fire) state_next = we[grant_idx] ? WR : RD;
            RD:   if (rd_done || rd_abort) state_next = IDLE;
            WR:   if (wr_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's request at the grant edge, then step address and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_reg     <= '0;
            ram_addr_reg <= '0;
            size_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
        end else if (grant_fire) begin
            port_reg     <= grant_idx;
            ram_addr_reg <= addr_arr[grant_idx];
            size_reg     <= size_arr[grant_idx];
            wdata_reg    <= wdata_arr[grant_idx];
            cnt_reg      <= '0;
        end else if (state_reg != IDLE) begin
            ram_addr_reg <= ram_addr_reg + ADDR_W'(1);
            cnt_reg      <= cnt_reg + CNT_W'(1);
        end
    end

    // Read assembly: byte k arrives when cnt_reg == k+1. Earlier bytes are
    // registered; the final byte is forwarded straight from ram_din on done.
    // Lanes are cleared at grant so bytes beyond the size read back as zero.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst || grant_fire) begin
                rbuf_reg[gi] <= 8'h00;
            end else if (state_reg == RD && cnt_reg == CNT_W'(gi + 1)) begin
                rbuf_reg[gi] <= ram_din;
            end
        end

        assign rdata[gi*8 +: 8] = !rd_done                      ? 8'h00   :
                                  (cnt_reg == CNT_W'(gi + 1))   ? ram_din :
                                                                  rbuf_reg[gi];
    end

    // Completion pulse goes to the port that owns the transaction.
    always_comb begin
        done = '0;
        if (rd_done || wr_done) begin
            done[port_reg] = 1'b1;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign ram_addr = ram_addr_reg;
    assign ram_wr   = (state_reg == WR);
    assign ram_dout = (state_reg == WR) ? byte_lane(64'(wdata_reg), cnt_reg[2:0]) : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide RAM model (1-cycle read latency).
// Expected grant order follows MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   we = '0;
    logic [NP-1:0]   abort = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*SW-1:0] size = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP-1:0]   done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   ram_addr;
    logic            ram_wr;
    logic [7:0]      ram_dout;
    logic [7:0]      ram_din = 8'h00;

    logic [7:0]      ram_mem [0:4095];

    int checks = 0;
    int failures = 0;

    mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SIZE_W    (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .abort    (abort),
        .addr     (addr),
        .size     (size),
        .wdata    (wdata),
        .done     (done),
        .rdata    (rdata),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    always #5 clk = ~clk;

    // RAM model: registered read of the address driven this cycle, byte write.
    always @(posedge clk) begin
        ram_din <= ram_mem[ram_addr[11:0]];
        if (ram_wr) ram_mem[ram_addr[11:0]] <= ram_dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-edge request on port p while the DUT is idle; returns in cycle 1.
    task automatic start(input int p, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d);
        req        = '0;
        req[p]     = 1'b1;
        we[p]      = w;
        addr[p*AW +: AW]  = a;
        size[p*SW +: SW]  = s;
        wdata[p*DW +: DW] = d;
        tick();
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
        ram_mem[12'h100] = 8'h11;
        ram_mem[12'h101] = 8'h22;
        ram_mem[12'h102] = 8'h33;
        ram_mem[12'h103] = 8'h44;
        ram_mem[12'h300] = 8'hA0;
        ram_mem[12'h310] = 8'hB1;
        ram_mem[12'hFFF] = 8'hAA;
        ram_mem[12'h000] = 8'h55;

        // Reset state
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_dout", ram_dout, 0);
        rst = 1'b0;
        tick();

        // T1: port0 4-byte read from 0x100, done in cycle 5
        start(0, 1'b0, 32'h100, 2'd3, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) check("t1_ram_addr", ram_addr, 64'(32'h100 + c - 1));
            if (c <= 4) check("t1_ram_wr", ram_wr, 0);
            check("t1_done", done, (c == 5) ? 2'b01 : 2'b00);
            if (c == 5) check("t1_rdata", rdata, 32'h44332211);
            if (c < 5) tick();
        end
        tick();
        check("t1_idle_busy", busy, 0);
        $display("txn t1 read p0 addr=100 size=3 rdata=%h", 32'h44332211);

        // T2: port1 2-byte write to 0x200
        start(1, 1'b1, 32'h200, 2'd1, 32'hBEEF);
        check("t2_c1_wr", ram_wr, 1);
        check("t2_c1_addr", ram_addr, 32'h200);
        check("t2_c1_dout", ram_dout, 8'hEF);
        check("t2_c1_done", done, 2'b00);
        tick();
        check("t2_c2_wr", ram_wr, 1);
        check("t2_c2_addr", ram_addr, 32'h201);
        check("t2_c2_dout", ram_dout, 8'hBE);
        check("t2_c2_done", done, 2'b10);
        tick();
        check("t2_c3_wr", ram_wr, 0);
        check("t2_c3_busy", busy, 0);
        check("t2_mem200", ram_mem[12'h200], 8'hEF);
        check("t2_mem201", ram_mem[12'h201], 8'hBE);
        $display("txn t2 write p1 addr=200 size=1 wdata=beef");

        // T3: both ports requesting continuously, single-byte reads
        req = 2'b11;
        we = 2'b00;
        addr = {32'h310, 32'h300};
        size = {2'd0, 2'd0};
        for (int t = 0; t < 4; t++) begin
            bit seen;
            int exp_port;
            seen = 1'b0;
`ifdef MEM_ARB_RR_EN
            exp_port = t % 2;
`else
            exp_port = 1;
`endif
            for (int b = 0; b < 10 && !seen; b++) begin
                tick();
                if (done != 2'b00) seen = 1'b1;
            end
            if (t == 3) req = 2'b00;
            if (!seen) begin
                check("t3_timeout", 0, 1);
            end else begin
                check("t3_grant", done, (exp_port == 1) ? 2'b10 : 2'b01);
                check("t3_rdata", rdata, (exp_port == 1) ? 32'hB1 : 32'hA0);
                $display("txn t3 read #%0d done=%b rdata=%h", t, done, rdata);
            end
        end
        tick();

        // T4: abort port0 read in cycle 2, port1 gets the next IDLE
        start(0, 1'b0, 32'h100, 2'd3, 32'h0);
        check("t4_c1_done", done, 0);
        tick();
        check("t4_c2_busy", busy, 1);
        abort = 2'b01;
        req = 2'b10;
        addr[AW +: AW] = 32'h310;
        size[SW +: SW] = 2'd0;
        we[1] = 1'b0;
        tick();
        check("t4_c3_busy", busy, 0);
        check("t4_c3_done", done, 0);
        abort = 2'b00;
        tick();
        req = 2'b00;
        check("t4_c4_busy", busy, 1);
        tick();
        check("t4_c5_done", done, 2'b10);
        check("t4_c5_rdata", rdata, 32'hB1);
        tick();
        $display("txn t4 abort p0, then read p1 rdata=%h", 32'hB1);

        // T5: abort during a write is ignored; then reset mid-read
        start(1, 1'b1, 32'h400, 2'd3, 32'hDDCCBBAA);
        abort = 2'b10;
        tick();
        check("t5_c2_wr", ram_wr, 1);
        tick();
        tick();
        check("t5_c4_done", done, 2'b10);
        abort = 2'b00;
        tick();
        check("t5_c5_busy", busy, 0);
        check("t5_mem400", ram_mem[12'h400], 8'hAA);
        check("t5_mem403", ram_mem[12'h403], 8'hDD);
        $display("txn t5 write p1 addr=400 with abort, wdata=ddccbbaa");
        start(0, 1'b0, 32'h100, 2'd3, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_rdata", rdata, 0);
        check("t5_rst_ram_addr", ram_addr, 0);
        check("t5_rst_ram_wr", ram_wr, 0);
        check("t5_rst_ram_dout", ram_dout, 0);
        rst = 1'b0;
        $display("txn t5 read p0 interrupted by rst");

        // T6: read across the address wrap
        start(0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0);
        check("t6_c1_addr", ram_addr, 32'hFFFF_FFFF);
        tick();
        check("t6_c2_addr", ram_addr, 32'h0);
        check("t6_c2_done", done, 0);
        tick();
        check("t6_c3_done", done, 2'b01);
        check("t6_rdata", rdata, 32'h000055AA);
        check("t6_rdata_hi", 64'(rdata[31:16]), 0);
        tick();
        $display("txn t6 read p0 addr=ffffffff size=1 rdata=%h", 32'h000055AA);

        // T7: req and abort together on a port in IDLE is not granted
        req = 2'b01;
        abort = 2'b01;
        addr[0 +: AW] = 32'h100;
        size[0 +: SW] = 2'd0;
        we[0] = 1'b0;
        tick();
        check("t7_blocked_busy", busy, 0);
        abort = 2'b00;
        tick();
        req = 2'b00;
        check("t7_granted_busy", busy, 1);
        tick();
        check("t7_done", done, 2'b01);
        check("t7_rdata", rdata, 32'h11);
        tick();
        $display("txn t7 read p0 addr=100 after blocked request rdata=%h", 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
